// File: rtl/reg_dst_tracker.sv
// reg_dst_tracker
//   Destination-register unit for the multicycle MIPS datapath. It picks the
//   write-back register from the RegDst code and records every non-$zero
//   destination in an in-order queue of pending writes. Two source registers
//   are checked against the queue for RAW hazards until their writes retire.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   RS, RT, IMMEDIATE    instruction fields (RD = IMMEDIATE[15:11])
//   RegDst               0=RT 1=RD 2=SP_REG 3=RA_REG 4=RS, 5-7 illegal
//   issue_valid/_ready   push handshake for the selected destination
//   retire               oldest pending write has completed
//   src_a, src_b         sources of the instruction being decoded
//   hazard_a, hazard_b   source matches a pending destination
//   dst_sel              combinational selected destination
//   dst_q                destination latched at the last accepted issue
//   retire_dst           destination at the head of the queue (0 when empty)
//   pending, full, empty queue occupancy
//   err_sel, err_uflow   sticky error flags (illegal RegDst issued, retire while empty)
module reg_dst_tracker #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          RS,
    input  logic [ADDR_W-1:0]          RT,
    input  logic [15:0]                IMMEDIATE,
    input  logic [2:0]                 RegDst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       retire,
    input  logic [ADDR_W-1:0]          src_a,
    input  logic [ADDR_W-1:0]          src_b,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic [ADDR_W-1:0]          dst_sel,
    output logic [ADDR_W-1:0]          dst_q,
    output logic [ADDR_W-1:0]          retire_dst,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       full,
    output logic                       empty,
    output logic                       err_sel,
    output logic                       err_uflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_REG);
    localparam logic [ADDR_W-1:0] RA_ADDR  = ADDR_W'(RA_REG);

    logic [ADDR_W-1:0] dst_mem_q [DEPTH];
    logic [ADDR_W-1:0] dst_mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] dst_d;
    logic              err_sel_q, err_sel_d;
    logic              err_uflow_q, err_uflow_d;

    logic accept, push, pop;
    logic hit_a, hit_b;

    // Only the RD field of the immediate is used here.
    logic imm_unused;
    assign imm_unused = ^IMMEDIATE[10:0];

    always_comb begin
        dst_sel = '0;
        case (RegDst)
            3'd0:    dst_sel = RT;
            3'd1:    dst_sel = ADDR_W'(IMMEDIATE[15:11]);
            3'd2:    dst_sel = SP_ADDR;
            3'd3:    dst_sel = RA_ADDR;
            3'd4:    dst_sel = RS;
            default: dst_sel = '0;
        endcase
    end

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign pending     = count_q;
    // A retire in the same cycle frees the head slot, so a full queue can still take an issue.
    assign issue_ready = !full || retire;
    assign accept      = issue_valid && issue_ready;
    // $zero (and every illegal code) is accepted but never tracked.
    assign push        = accept && (dst_sel != '0);
    assign pop         = retire && !empty;

    assign retire_dst  = (!empty && valid_q[head_q]) ? dst_mem_q[head_q] : '0;
    assign err_sel     = err_sel_q;
    assign err_uflow   = err_uflow_q;

    // Hazards look at registered entries only: a same-cycle issue is not yet
    // visible and a same-cycle retire is still counted.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (dst_mem_q[i] == src_a)) hit_a = 1'b1;
            if (valid_q[i] && (dst_mem_q[i] == src_b)) hit_b = 1'b1;
        end
        hazard_a = hit_a && (src_a != '0);
        hazard_b = hit_b && (src_b != '0);
    end

    always_comb begin
        valid_d     = valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        dst_d       = dst_q;
        err_sel_d   = err_sel_q;
        err_uflow_d = err_uflow_q;
        for (int i = 0; i < DEPTH; i++) begin
            dst_mem_d[i] = dst_mem_q[i];
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end else if (retire) begin
            err_uflow_d = 1'b1;
        end

        if (accept) begin
            dst_d = dst_sel;
            if (RegDst > 3'd4) err_sel_d = 1'b1;
        end

        // Push after pop: when both hit the same slot (full queue) the new entry wins.
        if (push) begin
            dst_mem_d[tail_q] = dst_sel;
            valid_d[tail_q]   = 1'b1;
            tail_d            = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dst_q       <= '0;
            err_sel_q   <= 1'b0;
            err_uflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_mem_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dst_q       <= dst_d;
            err_sel_q   <= err_sel_d;
            err_uflow_q <= err_uflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                dst_mem_q[i] <= dst_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_dst_tracker.sv
// Testbench for reg_dst_tracker: directed scenarios plus randomized traffic,
// all compared against a queue-based model of pending register writes.
module tb_reg_dst_tracker;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] RS, RT, src_a, src_b;
    logic [15:0]       IMMEDIATE;
    logic [2:0]        RegDst;
    logic              issue_valid, retire;
    logic              issue_ready, hazard_a, hazard_b, full, empty, err_sel, err_uflow;
    logic [ADDR_W-1:0] dst_sel, dst_q, retire_dst;
    logic [CNT_W-1:0]  pending;

    int total = 0;
    int bad   = 0;

    int mq[$];
    int m_dst_q;
    bit m_err_sel, m_err_uflow;

    reg_dst_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_REG(29), .RA_REG(31)) dut (
        .clk(clk), .reset(reset), .RS(RS), .RT(RT), .IMMEDIATE(IMMEDIATE),
        .RegDst(RegDst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .retire(retire), .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a),
        .hazard_b(hazard_b), .dst_sel(dst_sel), .dst_q(dst_q), .retire_dst(retire_dst),
        .pending(pending), .full(full), .empty(empty), .err_sel(err_sel),
        .err_uflow(err_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_sel(int code, int rs, int rt, int imm);
        case (code)
            0: return rt;
            1: return (imm >> 11) & 31;
            2: return 29;
            3: return 31;
            4: return rs;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_haz(int s);
        if (s == 0) return 1'b0;
        foreach (mq[k]) if (mq[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_head();
        return (mq.size() > 0) ? mq[0] : 0;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_dst_q     = 0;
        m_err_sel   = 1'b0;
        m_err_uflow = 1'b0;
    endfunction

    // Advance one clock and apply the reference rules to the inputs held across the edge.
    task automatic tick();
        bit acc;
        int sel;
        sel = m_sel(int'(RegDst), int'(RS), int'(RT), int'(IMMEDIATE));
        acc = issue_valid && ((mq.size() < DEPTH) || retire);
        @(posedge clk);
        if (retire) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err_uflow = 1'b1;
        end
        if (acc) begin
            m_dst_q = sel;
            if (sel != 0) mq.push_back(sel);
            if (RegDst > 3'd4) m_err_sel = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input bit iv, input int code, input int rt, input bit rt_en);
        issue_valid = iv;
        RegDst      = 3'(code);
        RT          = 5'(rt);
        retire      = rt_en;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        RS = '0; IMMEDIATE = '0; src_a = '0; src_b = '0;
        m_reset();
        #12;
        total++; if (pending !== 3'd0)    begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
        total++; if (dst_q !== 5'd0)      begin bad++; $display("FAIL reset_dst_q got=%0d exp=0", dst_q); end
        total++; if (retire_dst !== 5'd0) begin bad++; $display("FAIL reset_retire_dst got=%0d exp=0", retire_dst); end
        total++; if ({err_sel, err_uflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {err_sel, err_uflow}); end
        reset = 1'b1;
        #4;
    endtask

    task automatic test_select();
        int exp_tab[5] = '{9, 11, 29, 31, 5};
        RS = 5'd5; RT = 5'd9; IMMEDIATE = 16'h5800; issue_valid = 1'b0; retire = 1'b0;
        for (int c = 0; c < 5; c++) begin
            RegDst = 3'(c);
            #1;
            total++;
            if (dst_sel !== 5'(exp_tab[c])) begin
                bad++; $display("FAIL select_code%0d got=%0d exp=%0d", c, dst_sel, exp_tab[c]);
            end
        end
        RegDst = 3'd6; issue_valid = 1'b1;
        #1;
        total++; if (dst_sel !== 5'd0) begin bad++; $display("FAIL select_illegal got=%0d exp=0", dst_sel); end
        tick();
        issue_valid = 1'b0;
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL select_illegal_pending got=%0d exp=0", pending); end
        total++; if (err_sel !== 1'b1) begin bad++; $display("FAIL select_err_sel got=%0b exp=1", err_sel); end
        total++; if (dst_q !== 5'd0)   begin bad++; $display("FAIL select_dst_q got=%0d exp=0", dst_q); end
    endtask

    task automatic test_full();
        for (int v = 8; v <= 11; v++) begin
            drive(1, 0, v, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        total++; if (full !== 1'b1)        begin bad++; $display("FAIL full_flag got=%0b exp=1", full); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", issue_ready); end
        total++; if (pending !== 3'd4)     begin bad++; $display("FAIL full_pending got=%0d exp=4", pending); end
        drive(1, 0, 20, 0);
        tick();
        total++; if (pending !== 3'd4)           begin bad++; $display("FAIL full_reject_pending got=%0d exp=4", pending); end
        total++; if (dst_q !== 5'(m_dst_q))      begin bad++; $display("FAIL full_reject_dst_q got=%0d exp=%0d", dst_q, m_dst_q); end
        drive(1, 0, 12, 1);
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_ready_retire got=%0b exp=1", issue_ready); end
        tick();
        total++; if (pending !== 3'd4)     begin bad++; $display("FAIL full_swap_pending got=%0d exp=4", pending); end
        total++; if (retire_dst !== 5'd9)  begin bad++; $display("FAIL full_swap_head got=%0d exp=9", retire_dst); end
        total++; if (dst_q !== 5'd12)      begin bad++; $display("FAIL full_swap_dst_q got=%0d exp=12", dst_q); end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1);
            tick();
            total++;
            if (retire_dst !== 5'(m_head())) begin
                bad++; $display("FAIL full_drain%0d got=%0d exp=%0d", k, retire_dst, m_head());
            end
        end
        drive(0, 0, 0, 0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_hazard();
        drive(1, 0, 8, 0); tick();
        drive(1, 0, 9, 0); tick();
        drive(0, 0, 0, 0);
        src_a = 5'd9; src_b = 5'd0;
        #1;
        total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL haz_a_set got=%0b exp=1", hazard_a); end
        total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL haz_b_zero got=%0b exp=0", hazard_b); end
        src_b = 5'd7;
        drive(1, 0, 7, 0);
        #1;
        total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL haz_same_cycle_issue got=%0b exp=0", hazard_b); end
        tick();
        total++; if (hazard_b !== 1'b1) begin bad++; $display("FAIL haz_after_issue got=%0b exp=1", hazard_b); end
        drive(0, 0, 0, 1);
        tick();
        total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL haz_after_retire1 got=%0b exp=1", hazard_a); end
        #1;
        total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL haz_same_cycle_retire got=%0b exp=1", hazard_a); end
        tick();
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL haz_after_retire2 got=%0b exp=0", hazard_a); end
        tick();
        drive(0, 0, 0, 0);
        total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL haz_b_cleared got=%0b exp=0", hazard_b); end
        src_a = '0; src_b = '0;
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, i, 0);
            tick();
            total++;
            if (retire_dst !== 5'(i) || pending !== 3'd1) begin
                bad++; $display("FAIL wrap_issue%0d head=%0d pend=%0d exp_head=%0d exp_pend=1", i, retire_dst, pending, i);
            end
            drive(0, 0, 0, 1);
            tick();
            total++;
            if (empty !== 1'b1 || pending !== 3'd0) begin
                bad++; $display("FAIL wrap_retire%0d empty=%0b pend=%0d exp_empty=1 exp_pend=0", i, empty, pending);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_underflow();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        total++; if (pending !== 3'd0)   begin bad++; $display("FAIL uflow_pending got=%0d exp=0", pending); end
        total++; if (err_uflow !== 1'b1) begin bad++; $display("FAIL uflow_flag got=%0b exp=1", err_uflow); end
        repeat (3) tick();
        total++; if (err_uflow !== 1'b1) begin bad++; $display("FAIL uflow_sticky got=%0b exp=1", err_uflow); end
    endtask

    task automatic test_reset_mid();
        for (int v = 13; v <= 15; v++) begin
            drive(1, 0, v, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        src_a = 5'd14;
        #1;
        total++; if (pending !== 3'd3 || hazard_a !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre pend=%0d haz=%0b exp_pend=3 exp_haz=1", pending, hazard_a);
        end
        reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        total++; if (pending !== 3'd0 || empty !== 1'b1) begin
            bad++; $display("FAIL rstmid_queue pend=%0d empty=%0b exp_pend=0 exp_empty=1", pending, empty);
        end
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL rstmid_hazard got=%0b exp=0", hazard_a); end
        total++; if ({err_sel, err_uflow} !== 2'b00) begin bad++; $display("FAIL rstmid_err got=%b exp=00", {err_sel, err_uflow}); end
        #3;
        reset = 1'b1;
        src_a = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int exp_sel;
        for (int n = 0; n < 400; n++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            retire      = ($urandom_range(0, 2) == 0);
            RegDst      = 3'($urandom_range(0, 7));
            RS          = 5'($urandom_range(0, 15));
            RT          = 5'($urandom_range(0, 15));
            IMMEDIATE   = 16'($urandom);
            src_a       = 5'($urandom_range(0, 15));
            src_b       = 5'($urandom_range(0, 15));
            #1;
            exp_sel = m_sel(int'(RegDst), int'(RS), int'(RT), int'(IMMEDIATE));
            total++; if (dst_sel !== 5'(exp_sel)) begin bad++; $display("FAIL rnd%0d dst_sel got=%0d exp=%0d", n, dst_sel, exp_sel); end
            total++; if (issue_ready !== ((mq.size() < DEPTH) || retire)) begin
                bad++; $display("FAIL rnd%0d issue_ready got=%0b exp=%0b", n, issue_ready, (mq.size() < DEPTH) || retire);
            end
            total++; if (hazard_a !== m_haz(int'(src_a))) begin bad++; $display("FAIL rnd%0d hazard_a got=%0b exp=%0b", n, hazard_a, m_haz(int'(src_a))); end
            total++; if (hazard_b !== m_haz(int'(src_b))) begin bad++; $display("FAIL rnd%0d hazard_b got=%0b exp=%0b", n, hazard_b, m_haz(int'(src_b))); end
            tick();
            total++; if (pending !== 3'(mq.size())) begin bad++; $display("FAIL rnd%0d pending got=%0d exp=%0d", n, pending, mq.size()); end
            total++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                bad++; $display("FAIL rnd%0d status full=%0b empty=%0b exp_size=%0d", n, full, empty, mq.size());
            end
            total++; if (retire_dst !== 5'(m_head())) begin bad++; $display("FAIL rnd%0d retire_dst got=%0d exp=%0d", n, retire_dst, m_head()); end
            total++; if (dst_q !== 5'(m_dst_q)) begin bad++; $display("FAIL rnd%0d dst_q got=%0d exp=%0d", n, dst_q, m_dst_q); end
            total++; if (err_sel !== m_err_sel || err_uflow !== m_err_uflow) begin
                bad++; $display("FAIL rnd%0d err got=%b exp=%b", n, {err_sel, err_uflow}, {m_err_sel, m_err_uflow});
            end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_select();
        test_full();
        test_hazard();
        test_wrap();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
